audio_fifo_ctrl: RTL and testbench

AUDIO_FIFO_CTRL -- requirements
Module: audio_fifo_ctrl

---
 rtl/audio_fifo_ctrl_if.sv | 34 +++
 rtl/audio_fifo_ctrl.sv | 156 +++++++++++++++
 tb/tb_audio_fifo_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_fifo_ctrl_if.sv
// Controller-side bundle: mode pulses, microphone input, FIFO strobes/flags and playback output.
// master is the controller's view; slave is the environment driving the mode/mic/FIFO inputs.
interface audio_fifo_ctrl_if #(
    parameter int DBITS = 8
) ();
    logic             start_rec;
    logic             start_play;
    logic             stop;
    logic [DBITS-1:0] mic_data;
    logic             mic_valid;
    logic             fifo_full;
    logic             fifo_empty;
    logic [DBITS-1:0] fifo_dout;
    logic             fifo_wr;
    logic             fifo_rd;
    logic [DBITS-1:0] fifo_din;
    logic [DBITS-1:0] pcm_out;
    logic             pcm_valid;
    logic             busy;
    logic             overrun;
    logic [1:0]       state;

    modport master (
        input  start_rec, start_play, stop, mic_data, mic_valid,
               fifo_full, fifo_empty, fifo_dout,
        output fifo_wr, fifo_rd, fifo_din, pcm_out, pcm_valid, busy, overrun, state
    );

    modport slave (
        output start_rec, start_play, stop, mic_data, mic_valid,
               fifo_full, fifo_empty, fifo_dout,
        input  fifo_wr, fifo_rd, fifo_din, pcm_out, pcm_valid, busy, overrun, state
    );
endinterface

// File: rtl/audio_fifo_ctrl.sv
// Record/playback sequencer for a sample FIFO: one strobe, then SETTLE quiet cycles before flags/data are trusted.
// Strobes and pcm_out are registered; playback reads are paced by a DIV-cycle tick, with one tick held if busy.
module audio_fifo_ctrl #(
    parameter int DBITS  = 8,
    parameter int DIV    = 3125,
    parameter int SETTLE = 4
) (
    input  logic              clock,
    input  logic              reset,
    audio_fifo_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REC       = 2'd1,
        PLAY      = 2'd2,
        SETTLE_ST = 2'd3
    } state_t;

    localparam int            SW          = $clog2(SETTLE + 1);
    localparam logic [15:0]   DIV_LAST    = 16'(DIV - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

    state_t           state_q, state_d;
    logic             fifo_wr_q, fifo_wr_d;
    logic             fifo_rd_q, fifo_rd_d;
    logic             pcm_valid_q, pcm_valid_d;
    logic             overrun_q, overrun_d;
    logic [DBITS-1:0] fifo_din_q, fifo_din_d;
    logic [DBITS-1:0] pcm_out_q, pcm_out_d;
    logic [15:0]      tick_cnt_q, tick_cnt_d;
    logic [SW-1:0]    settle_cnt_q, settle_cnt_d;
    logic             pend_q, pend_d;
    logic             stop_mem_q, stop_mem_d;
    logic             from_play_q, from_play_d;
    logic             tick;

    assign tick = (tick_cnt_q == DIV_LAST);

    always_comb begin
        state_d      = state_q;
        fifo_wr_d    = 1'b0;
        fifo_rd_d    = 1'b0;
        pcm_valid_d  = 1'b0;
        overrun_d    = overrun_q;
        fifo_din_d   = fifo_din_q;
        pcm_out_d    = pcm_out_q;
        tick_cnt_d   = tick ? 16'd0 : tick_cnt_q + 16'd1;
        settle_cnt_d = settle_cnt_q;
        pend_d       = pend_q;
        stop_mem_d   = stop_mem_q;
        from_play_d  = from_play_q;

        case (state_q)
            IDLE: begin
                pend_d     = 1'b0;
                stop_mem_d = 1'b0;
                if (bus.start_rec) begin
                    state_d   = REC;
                    overrun_d = 1'b0;
                end else if (bus.start_play) begin
                    state_d    = PLAY;
                    tick_cnt_d = 16'd0;
                end
            end
            REC: begin
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (bus.mic_valid) begin
                    if (bus.fifo_full) begin
                        overrun_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        fifo_din_d   = bus.mic_data;
                        fifo_wr_d    = 1'b1;
                        settle_cnt_d = '0;
                        from_play_d  = 1'b0;
                        state_d      = SETTLE_ST;
                    end
                end
            end
            PLAY: begin
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (tick || pend_q) begin
                    pend_d = 1'b0;
                    if (bus.fifo_empty) begin
                        state_d = IDLE;
                    end else begin
                        fifo_rd_d    = 1'b1;
                        settle_cnt_d = '0;
                        from_play_d  = 1'b1;
                        state_d      = SETTLE_ST;
                    end
                end
            end
            default: begin
                settle_cnt_d = settle_cnt_q + SW'(1);
                if (tick && from_play_q) pend_d = 1'b1;
                if (bus.stop) stop_mem_d = 1'b1;
                // Read data is only trusted on the final settle cycle.
                if (settle_cnt_q == SETTLE_LAST) begin
                    if (from_play_q) begin
                        pcm_out_d   = bus.fifo_dout;
                        pcm_valid_d = 1'b1;
                    end
                    stop_mem_d = 1'b0;
                    if (stop_mem_q || bus.stop) begin
                        state_d = IDLE;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = from_play_q ? PLAY : REC;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            fifo_wr_q    <= 1'b0;
            fifo_rd_q    <= 1'b0;
            pcm_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
            fifo_din_q   <= '0;
            pcm_out_q    <= '0;
            tick_cnt_q   <= 16'd0;
            settle_cnt_q <= '0;
            pend_q       <= 1'b0;
            stop_mem_q   <= 1'b0;
            from_play_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            fifo_wr_q    <= fifo_wr_d;
            fifo_rd_q    <= fifo_rd_d;
            pcm_valid_q  <= pcm_valid_d;
            overrun_q    <= overrun_d;
            fifo_din_q   <= fifo_din_d;
            pcm_out_q    <= pcm_out_d;
            tick_cnt_q   <= tick_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            pend_q       <= pend_d;
            stop_mem_q   <= stop_mem_d;
            from_play_q  <= from_play_d;
        end
    end

    assign bus.fifo_wr   = fifo_wr_q;
    assign bus.fifo_rd   = fifo_rd_q;
    assign bus.fifo_din  = fifo_din_q;
    assign bus.pcm_out   = pcm_out_q;
    assign bus.pcm_valid = pcm_valid_q;
    assign bus.overrun   = overrun_q;
    assign bus.state     = state_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_audio_fifo_ctrl.sv
// Bench for audio_fifo_ctrl: directed record/playback/stop/reset scenarios, then random traffic
// checked every cycle against a timeline model (absolute tick times and settle end times).
module tb_audio_fifo_ctrl;
    localparam int DIV    = 8;
    localparam int SETTLE = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    audio_fifo_ctrl_if #(.DBITS(8)) bus ();

    audio_fifo_ctrl #(.DBITS(8), .DIV(DIV), .SETTLE(SETTLE)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: ticks fall where (cycle - play_t0) % DIV == DIV-1; a settle window ends at settle_end.
    int         cyc = 0;
    int         play_t0 = 0;
    int         settle_end = 0;
    int         last_strobe = -1000;
    logic [1:0] orig = 2'd0;
    logic [1:0] e_state = 2'd0;
    logic       e_wr = 1'b0, e_rd = 1'b0, e_pv = 1'b0, e_ovr = 1'b0;
    logic [7:0] e_din = 8'h00, e_pcm = 8'h00;
    bit         pend = 1'b0, stopm = 1'b0, started = 1'b0, e_rst = 1'b0, tk;

    initial forever begin
        @(posedge clock);
        started = 1'b1;
        e_rst   = reset;
        e_wr = 1'b0; e_rd = 1'b0; e_pv = 1'b0;
        if (reset) begin
            e_state = 2'd0; e_din = 8'h00; e_pcm = 8'h00; e_ovr = 1'b0;
            pend = 1'b0; stopm = 1'b0;
        end else begin
            tk = (cyc >= play_t0) && (((cyc - play_t0) % DIV) == DIV - 1);
            case (e_state)
                2'd0: begin
                    if (bus.start_rec) begin
                        e_state = 2'd1; e_ovr = 1'b0;
                    end else if (bus.start_play) begin
                        e_state = 2'd2; play_t0 = cyc + 1; pend = 1'b0;
                    end
                end
                2'd1: begin
                    if (bus.stop) e_state = 2'd0;
                    else if (bus.mic_valid) begin
                        if (bus.fifo_full) begin
                            e_ovr = 1'b1; e_state = 2'd0;
                        end else begin
                            e_din = bus.mic_data; e_wr = 1'b1; e_state = 2'd3;
                            settle_end = cyc + SETTLE; orig = 2'd1; stopm = 1'b0;
                        end
                    end
                end
                2'd2: begin
                    if (bus.stop) e_state = 2'd0;
                    else if (tk || pend) begin
                        pend = 1'b0;
                        if (bus.fifo_empty) e_state = 2'd0;
                        else begin
                            e_rd = 1'b1; e_state = 2'd3;
                            settle_end = cyc + SETTLE; orig = 2'd2; stopm = 1'b0;
                        end
                    end
                end
                default: begin
                    if (tk && orig == 2'd2) pend = 1'b1;
                    if (bus.stop) stopm = 1'b1;
                    if (cyc == settle_end) begin
                        if (orig == 2'd2) begin e_pcm = bus.fifo_dout; e_pv = 1'b1; end
                        if (stopm) begin e_state = 2'd0; pend = 1'b0; end
                        else e_state = orig;
                    end
                end
            endcase
        end
        cyc++;
    end

    initial forever begin
        @(negedge clock);
        if (started) begin
            chk("state",     32'(bus.state),     32'(e_state));
            chk("busy",      32'(bus.busy),      32'(e_state != 2'd0));
            chk("fifo_wr",   32'(bus.fifo_wr),   32'(e_wr));
            chk("fifo_rd",   32'(bus.fifo_rd),   32'(e_rd));
            chk("fifo_din",  32'(bus.fifo_din),  32'(e_din));
            chk("pcm_out",   32'(bus.pcm_out),   32'(e_pcm));
            chk("pcm_valid", 32'(bus.pcm_valid), 32'(e_pv));
            chk("overrun",   32'(bus.overrun),   32'(e_ovr));
            chk("wr_rd_excl", 32'(bus.fifo_wr & bus.fifo_rd), 0);
            if (e_rst) last_strobe = -1000;
            if (bus.fifo_wr || bus.fifo_rd) begin
                chk("strobe_gap_ok", 32'((cyc - last_strobe) >= SETTLE + 1), 1);
                last_strobe = cyc;
            end
        end
    end

    task automatic tick1();
        @(negedge clock);
        bus.start_rec = 1'b0; bus.start_play = 1'b0; bus.stop = 1'b0; bus.mic_valid = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, 32'(bus.state), 0);
        chk({tag, "_busy"},  32'(bus.busy), 0);
        chk({tag, "_wr"},    32'(bus.fifo_wr), 0);
        chk({tag, "_rd"},    32'(bus.fifo_rd), 0);
        chk({tag, "_din"},   32'(bus.fifo_din), 0);
        chk({tag, "_pcm"},   32'(bus.pcm_out), 0);
        chk({tag, "_pv"},    32'(bus.pcm_valid), 0);
        chk({tag, "_ovr"},   32'(bus.overrun), 0);
    endtask

    int rd1, rd2, pv1, pv2, n_rd, n_pv, st8, st9, st21;
    logic [7:0] pcm1, pcm2;

    initial begin
        reset = 1'b1;
        bus.start_rec = 1'b0; bus.start_play = 1'b0; bus.stop = 1'b0; bus.mic_valid = 1'b0;
        bus.mic_data = 8'h00; bus.fifo_full = 1'b0; bus.fifo_empty = 1'b0; bus.fifo_dout = 8'h00;
        tick1(); tick1();
        reset = 1'b0;
        chk_reset_vals("rst");
        tick1();

        // Record path
        bus.start_rec = 1'b1;
        tick1();
        chk("rec_entry", 32'(bus.state), 1);
        bus.mic_valid = 1'b1; bus.mic_data = 8'h5A;
        tick1();
        chk("rec_wr", 32'(bus.fifo_wr), 1);
        chk("rec_din", 32'(bus.fifo_din), 'h5A);
        chk("model_din", 32'(e_din), 'h5A);
        chk("rec_settle0", 32'(bus.state), 3);
        for (int i = 1; i < SETTLE; i++) begin
            tick1();
            chk("rec_settle_st", 32'(bus.state), 3);
            chk("rec_wr_low", 32'(bus.fifo_wr), 0);
        end
        tick1();
        chk("rec_back", 32'(bus.state), 1);

        // Overrun, then cleared by a fresh start_rec
        bus.fifo_full = 1'b1; bus.mic_valid = 1'b1;
        tick1();
        chk("ovr_wr", 32'(bus.fifo_wr), 0);
        chk("ovr_set", 32'(bus.overrun), 1);
        chk("ovr_state", 32'(bus.state), 0);
        bus.fifo_full = 1'b0; bus.start_rec = 1'b1;
        tick1();
        chk("ovr_clr", 32'(bus.overrun), 0);
        chk("ovr_rec", 32'(bus.state), 1);
        bus.stop = 1'b1;
        tick1();
        chk("rec_stop", 32'(bus.state), 0);

        // Playback, then stop in the cycle after the second read
        bus.fifo_empty = 1'b0; bus.fifo_dout = 8'h33; bus.start_play = 1'b1;
        rd1 = -1; rd2 = -1; pv1 = -1; pv2 = -1; n_rd = 0; n_pv = 0; st21 = -1;
        pcm1 = 8'h00; pcm2 = 8'h00;
        for (int k = 1; k <= 30; k++) begin
            tick1();
            if (bus.fifo_rd) begin
                n_rd++;
                if (n_rd == 1) rd1 = k; else if (n_rd == 2) rd2 = k;
            end
            if (bus.pcm_valid) begin
                n_pv++;
                if (n_pv == 1) begin pv1 = k; pcm1 = bus.pcm_out; end
                else if (n_pv == 2) begin pv2 = k; pcm2 = bus.pcm_out; end
            end
            if (k == 21) st21 = 32'(bus.state);
            if (k == 18) begin bus.stop = 1'b1; bus.fifo_dout = 8'h77; end
        end
        chk("play_rd1_cyc", rd1, 9);
        chk("play_pv1_cyc", pv1, 13);
        chk("play_pcm1", 32'(pcm1), 'h33);
        chk("play_rd2_cyc", rd2, 17);
        chk("stop_pv2_cyc", pv2, 21);
        chk("stop_pcm2", 32'(pcm2), 'h77);
        chk("stop_state", st21, 0);
        chk("stop_rd_count", n_rd, 2);
        chk("stop_pv_count", n_pv, 2);

        // Underflow at the first tick
        bus.fifo_empty = 1'b1; bus.start_play = 1'b1;
        n_rd = 0; n_pv = 0; st8 = -1; st9 = -1;
        for (int k = 1; k <= 12; k++) begin
            tick1();
            if (bus.fifo_rd) n_rd++;
            if (bus.pcm_valid) n_pv++;
            if (k == 8) st8 = 32'(bus.state);
            if (k == 9) st9 = 32'(bus.state);
        end
        chk("udf_play", st8, 2);
        chk("udf_idle", st9, 0);
        chk("udf_no_rd", n_rd, 0);
        chk("udf_no_pv", n_pv, 0);

        // Simultaneous starts, then reset mid-settle
        bus.fifo_empty = 1'b0; bus.start_rec = 1'b1; bus.start_play = 1'b1;
        tick1();
        chk("both_start", 32'(bus.state), 1);
        bus.mic_valid = 1'b1; bus.mic_data = 8'hA5;
        tick1();
        chk("rst_pre_wr", 32'(bus.fifo_wr), 1);
        tick1();
        chk("rst_pre_settle", 32'(bus.state), 3);
        reset = 1'b1;
        tick1();
        reset = 1'b0;
        chk_reset_vals("midrst");
        repeat (6) tick1();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            tick1();
            reset          = ($urandom_range(0, 399) == 0);
            bus.start_rec  = ($urandom_range(0, 29) == 0);
            bus.start_play = ($urandom_range(0, 24) == 0);
            bus.stop       = ($urandom_range(0, 59) == 0);
            bus.mic_valid  = ($urandom_range(0, 4) == 0);
            bus.mic_data   = 8'($urandom);
            bus.fifo_full  = ($urandom_range(0, 3) == 0);
            bus.fifo_empty = ($urandom_range(0, 4) == 0);
            bus.fifo_dout  = 8'($urandom);
        end
        tick1();
        reset = 1'b0;
        repeat (3) tick1();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
